// File: rtl/ysyx_22041207_if_id_buffer_pkg.sv
// ============================================================================
// Module  : ysyx_22041207_if_id_buffer_pkg
// Brief   : Shared constants, state encoding and helpers for the IF/ID buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22041207_if_id_buffer_pkg;

  localparam int          PC_W_DEF   = 64;
  localparam int          INST_W_DEF = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [1:0] occupancy(input buf_state_e state);
    case (state)
      BUF_ONE:  occupancy = 2'd1;
      BUF_FULL: occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22041207_sat_cnt.sv
// ============================================================================
// Module  : ysyx_22041207_sat_cnt
// Brief   : Saturating up-counter with a 2-bit increment per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22041207_sat_cnt #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_count} + {{(WIDTH-1){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= INIT;
    end else if (w_sum[WIDTH]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ysyx_22041207_if_id_buffer.sv
// ============================================================================
// Module  : ysyx_22041207_if_id_buffer
// Brief   : 2-entry elastic FIFO between fetch and decode with EX-redirect flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22041207_if_id_buffer
  import ysyx_22041207_if_id_buffer_pkg::*;
#(
  parameter int                PC_W           = PC_W_DEF,
  parameter int                INST_W         = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP            = INST_W'(NOP_INST),
  parameter logic [31:0]       FLUSH_CNT_INIT = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              pc_delay,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  input  logic              flush,
  output logic [31:0]       flush_cnt
);

  buf_state_e        r_state;
  buf_state_e        w_state_nxt;
  logic [PC_W-1:0]   r_pc0;
  logic [INST_W-1:0] r_inst0;
  logic [PC_W-1:0]   r_pc1;
  logic [INST_W-1:0] r_inst1;

  logic       w_push;
  logic       w_pop;
  logic       w_load_head;
  logic       w_head_from_slot1;
  logic       w_load_slot1;
  logic [1:0] w_flush_inc;

  assign if_ready = (r_state != BUF_FULL);
  assign pc_delay = ~if_ready;
  assign id_valid = (r_state != BUF_EMPTY);
  assign w_push   = if_valid & if_ready;
  assign w_pop    = id_valid & id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush overrides every transition; the same-cycle push never lands.
  always_comb begin
    w_state_nxt       = r_state;
    w_load_head       = 1'b0;
    w_head_from_slot1 = 1'b0;
    w_load_slot1      = 1'b0;
    if (flush) begin
      w_state_nxt = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            w_state_nxt = BUF_ONE;
            w_load_head = 1'b1;
          end
        end
        BUF_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt  = BUF_FULL;
            w_load_slot1 = 1'b1;
          end else if (w_push && w_pop) begin
            w_load_head = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (w_pop) begin
            w_state_nxt       = BUF_ONE;
            w_head_from_slot1 = 1'b1;
          end
        end
        default: w_state_nxt = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc0   <= '0;
      r_inst0 <= NOP;
      r_pc1   <= '0;
      r_inst1 <= NOP;
    end else begin
      if (w_load_head) begin
        r_pc0   <= if_pc;
        r_inst0 <= if_inst;
      end else if (w_head_from_slot1) begin
        r_pc0   <= r_pc1;
        r_inst0 <= r_inst1;
      end
      if (w_load_slot1) begin
        r_pc1   <= if_pc;
        r_inst1 <= if_inst;
      end
    end
  end

  assign id_pc   = r_pc0;
  assign id_inst = id_valid ? r_inst0 : NOP;

  // A popped head was consumed, so only the remaining entries count as discarded.
  assign w_flush_inc = flush ? (occupancy(r_state) - {1'b0, w_pop}) : 2'd0;

  ysyx_22041207_sat_cnt #(
    .WIDTH (32),
    .INIT  (FLUSH_CNT_INIT)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041207_if_id_buffer.sv
// ============================================================================
// Module  : tb_ysyx_22041207_if_id_buffer
// Brief   : Directed self-checking bench for the IF/ID elastic buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22041207_if_id_buffer;

  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic        if_ready, pc_delay, id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst, flush_cnt;

  logic        s_if_valid = 1'b0;
  logic [63:0] s_if_pc = '0;
  logic [31:0] s_if_inst = '0;
  logic        s_id_ready = 1'b0;
  logic        s_flush = 1'b0;
  logic        s_if_ready, s_pc_delay, s_id_valid;
  logic [63:0] s_id_pc;
  logic [31:0] s_id_inst, s_flush_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ysyx_22041207_if_id_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .pc_delay(pc_delay),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ready(id_ready), .flush(flush), .flush_cnt(flush_cnt)
  );

  // Second instance starts its counter near the top so saturation is reachable.
  ysyx_22041207_if_id_buffer #(.FLUSH_CNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .if_valid(s_if_valid), .if_pc(s_if_pc), .if_inst(s_if_inst),
    .if_ready(s_if_ready), .pc_delay(s_pc_delay),
    .id_valid(s_id_valid), .id_pc(s_id_pc), .id_inst(s_id_inst),
    .id_ready(s_id_ready), .flush(s_flush), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [63:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  initial begin
    // 1: asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_inst", {32'd0, id_inst}, {32'd0, c_nop});
    chk("rst_if_ready", {63'd0, if_ready}, 64'd1);
    chk("rst_pc_delay", {63'd0, pc_delay}, 64'd0);
    chk("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
    chk("rst_id_pc", id_pc, 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // 2: streaming with decode always ready
    id_ready = 1'b1;
    offer(1'b1, 64'h8000_0000, 32'h0010_0093);
    #1;
    chk("no_comb_path", {63'd0, id_valid}, 64'd0);
    step();
    chk("s0_valid", {63'd0, id_valid}, 64'd1);
    chk("s0_pc", id_pc, 64'h8000_0000);
    chk("s0_inst", {32'd0, id_inst}, 64'h0010_0093);
    offer(1'b1, 64'h8000_0004, 32'h0020_0113);
    step();
    chk("s1_pc", id_pc, 64'h8000_0004);
    chk("s1_inst", {32'd0, id_inst}, 64'h0020_0113);
    chk("s1_if_ready", {63'd0, if_ready}, 64'd1);
    offer(1'b1, 64'h8000_0008, 32'h0030_0193);
    step();
    chk("s2_pc", id_pc, 64'h8000_0008);
    chk("s2_pc_delay", {63'd0, pc_delay}, 64'd0);
    chk("s2_valid", {63'd0, id_valid}, 64'd1);
    offer(1'b0, 64'h0, 32'h0);
    step();
    chk("s3_drain_valid", {63'd0, id_valid}, 64'd0);
    chk("s3_drain_inst", {32'd0, id_inst}, {32'd0, c_nop});

    // 3: back-pressure to FULL, then release
    id_ready = 1'b0;
    offer(1'b1, 64'h8000_0000, 32'h0010_0093);
    step();
    chk("bp_one_if_ready", {63'd0, if_ready}, 64'd1);
    offer(1'b1, 64'h8000_0004, 32'h0020_0113);
    step();
    chk("bp_full_if_ready", {63'd0, if_ready}, 64'd0);
    chk("bp_full_pc_delay", {63'd0, pc_delay}, 64'd1);
    chk("bp_full_pc", id_pc, 64'h8000_0000);
    offer(1'b1, 64'h8000_0008, 32'h0030_0193);
    step();
    chk("bp_hold_pc", id_pc, 64'h8000_0000);
    chk("bp_hold_inst", {32'd0, id_inst}, 64'h0010_0093);
    offer(1'b0, 64'h0, 32'h0);
    id_ready = 1'b1;
    step();
    chk("bp_pop1_pc", id_pc, 64'h8000_0004);
    chk("bp_pop1_inst", {32'd0, id_inst}, 64'h0020_0113);
    chk("bp_pop1_if_ready", {63'd0, if_ready}, 64'd1);
    step();
    chk("bp_pop2_valid", {63'd0, id_valid}, 64'd0);

    // 4: flush while FULL, decode stalled, fetch offering
    id_ready = 1'b0;
    offer(1'b1, 64'h8000_0100, 32'h0040_0213);
    step();
    offer(1'b1, 64'h8000_0104, 32'h0050_0293);
    step();
    offer(1'b1, 64'h8000_0108, 32'h0060_0313);
    flush = 1'b1;
    step();
    chk("fl_full_valid", {63'd0, id_valid}, 64'd0);
    chk("fl_full_inst", {32'd0, id_inst}, {32'd0, c_nop});
    chk("fl_full_cnt", {32'd0, flush_cnt}, 64'd2);
    chk("fl_full_if_ready", {63'd0, if_ready}, 64'd1);
    // flush in EMPTY with an acceptable push: push dropped, nothing counted
    step();
    chk("fl_empty_push_dropped", {63'd0, id_valid}, 64'd0);
    chk("fl_empty_cnt", {32'd0, flush_cnt}, 64'd2);
    flush = 1'b0;
    offer(1'b0, 64'h0, 32'h0);
    step();
    chk("fl_after_valid", {63'd0, id_valid}, 64'd0);

    // 5: flush with pop in ONE; push+pop in ONE
    id_ready = 1'b1;
    offer(1'b1, 64'h8000_0200, 32'h0070_0393);
    step();
    offer(1'b0, 64'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flpop_one_cnt", {32'd0, flush_cnt}, 64'd2);
    chk("flpop_one_valid", {63'd0, id_valid}, 64'd0);
    offer(1'b1, 64'h8000_0300, 32'h0080_0413);
    step();
    offer(1'b1, 64'h8000_0304, 32'h0090_0493);
    step();
    chk("pp_one_pc", id_pc, 64'h8000_0304);
    chk("pp_one_valid", {63'd0, id_valid}, 64'd1);
    chk("pp_one_if_ready", {63'd0, if_ready}, 64'd1);
    offer(1'b0, 64'h0, 32'h0);
    id_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_one_nopop_cnt", {32'd0, flush_cnt}, 64'd3);
    offer(1'b1, 64'h8000_0400, 32'h00a0_0513);
    step();
    offer(1'b1, 64'h8000_0404, 32'h00b0_0593);
    step();
    offer(1'b0, 64'h0, 32'h0);
    id_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_ready = 1'b0;
    chk("fl_full_pop_cnt", {32'd0, flush_cnt}, 64'd4);

    // 6: saturation on the preloaded instance
    chk("sat_init", {32'd0, s_flush_cnt}, 64'hFFFF_FFFE);
    s_if_valid = 1'b1;
    s_if_pc = 64'h8000_0500;
    s_if_inst = 32'h00c0_0613;
    step();
    s_if_pc = 64'h8000_0504;
    step();
    s_if_valid = 1'b0;
    chk("sat_full_if_ready", {63'd0, s_if_ready}, 64'd0);
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    chk("sat_reach", {32'd0, s_flush_cnt}, 64'hFFFF_FFFF);
    s_if_valid = 1'b1;
    step();
    step();
    s_if_valid = 1'b0;
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    chk("sat_hold", {32'd0, s_flush_cnt}, 64'hFFFF_FFFF);

    // mid-operation reset while FULL
    offer(1'b1, 64'h8000_0600, 32'h00d0_0693);
    step();
    offer(1'b1, 64'h8000_0604, 32'h00e0_0713);
    step();
    offer(1'b0, 64'h0, 32'h0);
    chk("pre_rst_full", {63'd0, if_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, id_valid}, 64'd0);
    chk("mid_rst_inst", {32'd0, id_inst}, {32'd0, c_nop});
    chk("mid_rst_if_ready", {63'd0, if_ready}, 64'd1);
    chk("mid_rst_cnt", {32'd0, flush_cnt}, 64'd0);
    chk("mid_rst_sat_cnt", {32'd0, s_flush_cnt}, 64'hFFFF_FFFE);
    step();
    rst_n = 1'b1;
    id_ready = 1'b1;
    offer(1'b1, 64'h8000_0700, 32'h00f0_0793);
    step();
    offer(1'b0, 64'h0, 32'h0);
    chk("post_rst_pc", id_pc, 64'h8000_0700);
    step();
    chk("post_rst_drain", {63'd0, id_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
